onehot_ptr: RTL and testbench
=============================

Name: onehot_ptr

Overview:
- Registered one-hot pointer over N positions; the sequential successor to the combinational binary-to-one-hot decoder.
- Loads from a binary index (decoded internally) or advances circularly to the next eligible position under a per-position mask.
- Used for cache way selection, round-robin arbitration and FIFO slot pointers.
- N is not restricted to a power of two.

Parameters:
- N, 4, number of positions (N >= 2).
- BW, $clog2(N), width of binary index; derived, not overridden.
- RESET_IDX, 0, position selected after reset (0 <= RESET_IDX < N).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- LoadEn  input  1  load pointer from LoadIdx this cycle.
- LoadIdx  input  BW  binary index to load.
- AdvanceEn  input  1  move pointer to next eligible position.
- Mask  input  N  bit i = 1 means position i is eligible for advance.
- OneHot  output  N  registered one-hot pointer; all-zero when invalid.
- Valid  output  1  registered; 1 when OneHot has exactly one bit set.
- Wrap  output  1  registered one-cycle pulse; last advance crossed from a higher index to a lower or equal index.
- NoneElig  output  1  combinational; Mask == 0.

Behaviour:
- Reset, synchronous, highest priority:
  - OneHot = 1 << RESET_IDX, Valid = 1, Wrap = 0.
  - Reset asserted mid-operation overrides LoadEn and AdvanceEn in the same cycle.
- Priority each cycle: reset > LoadEn > AdvanceEn > hold.
- Load:
  - LoadIdx < N: next OneHot = 1 << LoadIdx, Valid = 1, Wrap = 0.
  - LoadIdx >= N (possible when N is not a power of two): next OneHot = 0, Valid = 0, Wrap = 0.
  - Mask is ignored on load; an ineligible position may be loaded.
- Advance, with LoadEn = 0:
  - Valid = 1, current index c: next index is the first i in c+1, c+2, ..., N-1, 0, ..., c (modulo N) with Mask[i] = 1.
  - If c is the only eligible position, the pointer stays at c and Wrap = 1 (full circle).
  - Wrap = 1 when the selected i <= c; otherwise 0.
  - Valid = 0: next index is the lowest i with Mask[i] = 1; Valid becomes 1; Wrap = 0.
  - Mask == 0: pointer and Valid hold, Wrap = 0. NoneElig = 1 in that same cycle.
- Hold (no load, no advance): OneHot and Valid unchanged, Wrap = 0.
- Latency: one cycle from LoadEn/AdvanceEn to OneHot/Valid/Wrap.
- Wrap is a pulse; it is never held for more than one cycle without a new advance.
- Invariant: OneHot is either zero (Valid = 0) or has exactly one bit set (Valid = 1). OneHot never has two or more bits set.
- Arithmetic: circular search done on a doubled vector {Mask, Mask} masked above c, or an equivalent form. No modulo division; it must synthesise as a priority encoder.

Optional Feature:
- Macro: ONEHOT_PTR_BINOUT_EN.
- Defined: adds output port PtrIdx, output, BW bits.
  - Registered binary encoding of the pointer, updated in the same cycle as OneHot.
  - Reset value RESET_IDX; value 0 when Valid = 0.
- Not defined: PtrIdx port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset with N=4, RESET_IDX=2, Mask=4'b1111 -> OneHot=4'b0100, Valid=1, Wrap=0 on the first cycle after reset.
- Load LoadIdx=3 (N=4), then AdvanceEn with Mask=4'b1111 -> OneHot=4'b1000, then 4'b0001 with Wrap=1 for exactly one cycle, then Wrap=0 on hold.
- N=5, load LoadIdx=6 -> OneHot=0, Valid=0. Then AdvanceEn with Mask=5'b10100 -> OneHot=5'b00100, Valid=1, Wrap=0.
- Pointer at 1, Mask=4'b0010, AdvanceEn -> OneHot stays 4'b0010, Wrap=1. Then Mask=0 with AdvanceEn -> NoneElig=1, OneHot unchanged, Wrap=0.
- Same cycle LoadEn=1 (LoadIdx=0), AdvanceEn=1, pointer at 2 -> OneHot=4'b0001 (load wins). Same cycle reset=1, LoadEn=1 (LoadIdx=3) -> RESET_IDX position selected.
- With ONEHOT_PTR_BINOUT_EN defined, random load/advance sequence (1000 cycles, random Mask) -> PtrIdx always equals the index of the set OneHot bit (0 when Valid=0). Across all configurations, OneHot never has more than one bit set.

Source files
------------

// File: rtl/onehot_ptr_if.sv
// onehot_ptr_if: control/observation bundle for the one-hot pointer.
// PtrIdx exists only when ONEHOT_PTR_BINOUT_EN is defined.
interface onehot_ptr_if #(
   parameter int N = 4
);
   localparam int BW = $clog2(N);

   logic          LoadEn;
   logic [BW-1:0] LoadIdx;
   logic          AdvanceEn;
   logic [N-1:0]  Mask;
   logic [N-1:0]  OneHot;
   logic          Valid;
   logic          Wrap;
   logic          NoneElig;
`ifdef ONEHOT_PTR_BINOUT_EN
   logic [BW-1:0] PtrIdx;

   modport master (
      output LoadEn, LoadIdx, AdvanceEn, Mask,
      input  OneHot, Valid, Wrap, NoneElig, PtrIdx
   );

   modport slave (
      input  LoadEn, LoadIdx, AdvanceEn, Mask,
      output OneHot, Valid, Wrap, NoneElig, PtrIdx
   );
`else
   modport master (
      output LoadEn, LoadIdx, AdvanceEn, Mask,
      input  OneHot, Valid, Wrap, NoneElig
   );

   modport slave (
      input  LoadEn, LoadIdx, AdvanceEn, Mask,
      output OneHot, Valid, Wrap, NoneElig
   );
`endif
endinterface

// File: rtl/onehot_ptr.sv
// onehot_ptr: registered one-hot pointer with binary load and masked circular advance.
// Defining ONEHOT_PTR_BINOUT_EN adds the registered binary pointer output PtrIdx.
module onehot_ptr #(
   parameter int N         = 4,
   parameter int RESET_IDX = 0,
   localparam int BW       = $clog2(N)
) (
   input  logic        clk,
   input  logic        reset,
   onehot_ptr_if.slave bus
);

   // Indices into the doubled {Mask, Mask} vector need one extra bit.
   localparam int            DW        = BW + 1;
   localparam logic [DW-1:0] N_EXT     = DW'(N);
   localparam logic [N-1:0]  ONE_N     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]  RESET_OH  = ONE_N << RESET_IDX;
   localparam logic [BW-1:0] RESET_BIN = BW'(RESET_IDX);

   function automatic logic [BW-1:0] oh_to_bin(input logic [N-1:0] oh);
      logic [BW-1:0] idx;
      idx = {BW{1'b0}};
      for (int i = 0; i < N; i++) begin
         idx = idx | (oh[i] ? BW'(i) : {BW{1'b0}});
      end
      return idx;
   endfunction

   function automatic logic [DW-1:0] first_set(input logic [2*N-1:0] vec);
      logic [DW-1:0] pos;
      pos = {DW{1'b0}};
      for (int i = 2*N-1; i >= 0; i--) begin
         pos = vec[i] ? DW'(i) : pos;
      end
      return pos;
   endfunction

   logic [N-1:0]   onehot_r;
   logic           valid_r;
   logic           wrap_r;

   logic [BW-1:0]  cur_idx_s;
   logic [2*N-1:0] above_s;
   logic [2*N-1:0] search_s;
   logic [DW-1:0]  hit_s;
   logic [DW-1:0]  low_s;
   logic           none_elig_s;
   logic           load_ok_s;
   logic [N-1:0]   next_oh_s;
   logic           next_valid_s;
   logic           next_wrap_s;

   // Next-pointer selection: load beats advance, advance beats hold.
   always_comb begin
      cur_idx_s = oh_to_bin(onehot_r);
      above_s   = {(2*N){1'b0}};
      for (int i = 0; i < 2*N; i++) begin
         above_s[i] = (DW'(i) > {1'b0, cur_idx_s});
      end
      // Candidates strictly after c, wrapping through c itself in the upper copy.
      search_s     = {bus.Mask, bus.Mask} & above_s;
      hit_s        = first_set(search_s);
      low_s        = first_set({{N{1'b0}}, bus.Mask});
      none_elig_s  = (bus.Mask == {N{1'b0}});
      load_ok_s    = ({1'b0, bus.LoadIdx} < N_EXT);
      next_oh_s    = onehot_r;
      next_valid_s = valid_r;
      next_wrap_s  = 1'b0;
      if (bus.LoadEn) begin
         next_oh_s    = load_ok_s ? (ONE_N << bus.LoadIdx) : {N{1'b0}};
         next_valid_s = load_ok_s;
      end else if (bus.AdvanceEn && !none_elig_s) begin
         next_valid_s = 1'b1;
         if (!valid_r) begin
            next_oh_s = ONE_N << low_s;
         end else if (hit_s >= N_EXT) begin
            next_oh_s   = ONE_N << (hit_s - N_EXT);
            next_wrap_s = 1'b1;
         end else begin
            next_oh_s = ONE_N << hit_s;
         end
      end else begin
         next_oh_s    = onehot_r;
         next_valid_s = valid_r;
      end
   end

`ifdef ONEHOT_PTR_BINOUT_EN
   logic [BW-1:0] ptr_idx_r;
   logic [BW-1:0] next_bin_s;

   // Binary view of the next pointer; a zero pointer encodes to 0.
   always_comb begin
      next_bin_s = oh_to_bin(next_oh_s);
   end

   // Binary pointer register, updated alongside the one-hot register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_idx_r <= RESET_BIN;
      end else begin
         ptr_idx_r <= next_bin_s;
      end
   end

   assign bus.PtrIdx = ptr_idx_r;
`endif

   // Pointer, validity and wrap-pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         onehot_r <= RESET_OH;
         valid_r  <= 1'b1;
         wrap_r   <= 1'b0;
      end else begin
         onehot_r <= next_oh_s;
         valid_r  <= next_valid_s;
         wrap_r   <= next_wrap_s;
      end
   end

   assign bus.OneHot   = onehot_r;
   assign bus.Valid    = valid_r;
   assign bus.Wrap     = wrap_r;
   assign bus.NoneElig = none_elig_s;

endmodule

// File: tb/tb_onehot_ptr.sv
// Scoreboard bench for onehot_ptr: N=4 (RESET_IDX=2) and N=5 (RESET_IDX=0) instances.
// With ONEHOT_PTR_BINOUT_EN defined, PtrIdx is checked and a random phase runs on the N=4 instance.
module tb_onehot_ptr;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4;
   logic rst5;
   logic started = 1'b0;

   onehot_ptr_if #(.N(4)) bus4 ();
   onehot_ptr_if #(.N(5)) bus5 ();

   onehot_ptr #(.N(4), .RESET_IDX(2)) dut4 (.clk(clk), .reset(rst4), .bus(bus4.slave));
   onehot_ptr #(.N(5), .RESET_IDX(0)) dut5 (.clk(clk), .reset(rst5), .bus(bus5.slave));

   typedef struct packed {
      logic       sel;
      logic [4:0] oh;
      logic       v;
      logic       w;
   } exp_t;

   typedef struct packed {
      logic sel;
      logic ne;
   } ne_t;

   exp_t out_q[$];
   ne_t  ne_q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic int oh_idx(input logic [4:0] oh);
      for (int i = 0; i < 5; i++) begin
         if (oh[i]) return i;
      end
      return 0;
   endfunction

   task automatic step4(input logic r, input logic ld, input logic [1:0] li, input logic adv,
                        input logic [3:0] m, input logic [3:0] eoh, input logic ev, input logic ew);
      exp_t e;
      ne_t  n;
      rst4 = r; bus4.LoadEn = ld; bus4.LoadIdx = li; bus4.AdvanceEn = adv; bus4.Mask = m;
      n.sel = 1'b0; n.ne = (m == 4'b0000);
      ne_q.push_back(n);
      @(posedge clk);
      e.sel = 1'b0; e.oh = {1'b0, eoh}; e.v = ev; e.w = ew;
      out_q.push_back(e);
      #1;
   endtask

   task automatic step5(input logic r, input logic ld, input logic [2:0] li, input logic adv,
                        input logic [4:0] m, input logic [4:0] eoh, input logic ev, input logic ew);
      exp_t e;
      ne_t  n;
      rst5 = r; bus5.LoadEn = ld; bus5.LoadIdx = li; bus5.AdvanceEn = adv; bus5.Mask = m;
      n.sel = 1'b1; n.ne = (m == 5'b00000);
      ne_q.push_back(n);
      @(posedge clk);
      e.sel = 1'b1; e.oh = eoh; e.v = ev; e.w = ew;
      out_q.push_back(e);
      #1;
   endtask

   // Monitor: invariants every cycle, scoreboard pops when entries are due.
   initial begin : monitor
      exp_t e;
      ne_t  n;
      logic [4:0] a_oh;
      logic a_v, a_w, a_ne;
      forever begin
         @(negedge clk);
         if (started) begin
            checks++;
            if ($countones(bus4.OneHot) > 1 || (bus4.Valid != (bus4.OneHot != 4'b0000))) begin
               errors++;
               $display("FAIL inv4: OneHot=%b Valid=%b, required at most one bit and Valid matching", bus4.OneHot, bus4.Valid);
            end
            checks++;
            if ($countones(bus5.OneHot) > 1 || (bus5.Valid != (bus5.OneHot != 5'b00000))) begin
               errors++;
               $display("FAIL inv5: OneHot=%b Valid=%b, required at most one bit and Valid matching", bus5.OneHot, bus5.Valid);
            end
         end
         if (ne_q.size() > 0) begin
            n = ne_q.pop_front();
            a_ne = n.sel ? bus5.NoneElig : bus4.NoneElig;
            checks++;
            if (a_ne !== n.ne) begin
               errors++;
               $display("FAIL noneelig dut%0d: got %b expected %b", n.sel ? 5 : 4, a_ne, n.ne);
            end
         end
         if (out_q.size() > 0) begin
            e = out_q.pop_front();
            a_oh = n.sel ? 5'b00000 : 5'b00000;
            a_oh = e.sel ? bus5.OneHot : {1'b0, bus4.OneHot};
            a_v  = e.sel ? bus5.Valid : bus4.Valid;
            a_w  = e.sel ? bus5.Wrap : bus4.Wrap;
            checks++;
            if (a_oh !== e.oh || a_v !== e.v || a_w !== e.w) begin
               errors++;
               $display("FAIL out dut%0d: got oh=%b v=%b w=%b expected oh=%b v=%b w=%b",
                        e.sel ? 5 : 4, a_oh, a_v, a_w, e.oh, e.v, e.w);
            end
`ifdef ONEHOT_PTR_BINOUT_EN
            checks++;
            if ((e.sel ? int'(bus5.PtrIdx) : int'(bus4.PtrIdx)) != oh_idx(e.oh)) begin
               errors++;
               $display("FAIL ptridx dut%0d: got %0d expected %0d", e.sel ? 5 : 4,
                        e.sel ? int'(bus5.PtrIdx) : int'(bus4.PtrIdx), oh_idx(e.oh));
            end
`endif
         end
      end
   end

   initial begin : driver
      rst4 = 1'b1; rst5 = 1'b1;
      bus4.LoadEn = 1'b0; bus4.LoadIdx = 2'd0; bus4.AdvanceEn = 1'b0; bus4.Mask = 4'b1111;
      bus5.LoadEn = 1'b0; bus5.LoadIdx = 3'd0; bus5.AdvanceEn = 1'b0; bus5.Mask = 5'b11111;
      @(posedge clk);
      #1;
      rst4 = 1'b0; rst5 = 1'b0;
      started = 1'b1;

      //     rst  ld   li     adv  mask      exp oh   v     w
      step4(1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b0);
      step4(1'b0, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b0);
      step4(1'b0, 1'b1, 2'd3, 1'b0, 4'b1111, 4'b1000, 1'b1, 1'b0);
      step4(1'b0, 1'b0, 2'd0, 1'b1, 4'b1111, 4'b0001, 1'b1, 1'b1);
      step4(1'b0, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0);
      step4(1'b0, 1'b0, 2'd0, 1'b1, 4'b1010, 4'b0010, 1'b1, 1'b0);
      step4(1'b0, 1'b0, 2'd0, 1'b1, 4'b1010, 4'b1000, 1'b1, 1'b0);
      step4(1'b0, 1'b0, 2'd0, 1'b1, 4'b1010, 4'b0010, 1'b1, 1'b1);
      step4(1'b0, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1);
      step4(1'b0, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1);
      step4(1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0010, 1'b1, 1'b0);
      step4(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0);
      step4(1'b0, 1'b1, 2'd2, 1'b0, 4'b0001, 4'b0100, 1'b1, 1'b0);
      step4(1'b0, 1'b1, 2'd0, 1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0);
      step4(1'b1, 1'b1, 2'd3, 1'b1, 4'b1111, 4'b0100, 1'b1, 1'b0);
      step4(1'b0, 1'b0, 2'd0, 1'b1, 4'b1111, 4'b1000, 1'b1, 1'b0);
      step4(1'b0, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b1000, 1'b1, 1'b0);

      step5(1'b0, 1'b1, 3'd6, 1'b0, 5'b10100, 5'b00000, 1'b0, 1'b0);
      step5(1'b0, 1'b0, 3'd0, 1'b0, 5'b10100, 5'b00000, 1'b0, 1'b0);
      step5(1'b0, 1'b0, 3'd0, 1'b1, 5'b10100, 5'b00100, 1'b1, 1'b0);
      step5(1'b0, 1'b0, 3'd0, 1'b1, 5'b10100, 5'b10000, 1'b1, 1'b0);
      step5(1'b0, 1'b0, 3'd0, 1'b1, 5'b10100, 5'b00100, 1'b1, 1'b1);
      step5(1'b0, 1'b1, 3'd5, 1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0);
      step5(1'b0, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0);
      step5(1'b0, 1'b0, 3'd0, 1'b1, 5'b11000, 5'b01000, 1'b1, 1'b0);
      step5(1'b0, 1'b1, 3'd4, 1'b0, 5'b00000, 5'b10000, 1'b1, 1'b0);
      step5(1'b0, 1'b0, 3'd0, 1'b1, 5'b00001, 5'b00001, 1'b1, 1'b1);
      step5(1'b0, 1'b1, 3'd7, 1'b1, 5'b11111, 5'b00000, 1'b0, 1'b0);
      step5(1'b1, 1'b1, 3'd6, 1'b0, 5'b11111, 5'b00001, 1'b1, 1'b0);
      step5(1'b0, 1'b0, 3'd0, 1'b0, 5'b11111, 5'b00001, 1'b1, 1'b0);

`ifdef ONEHOT_PTR_BINOUT_EN
      begin : random_phase
         int         cur;
         logic       val;
         logic       w;
         logic       r, ld, adv;
         logic [1:0] li;
         logic [3:0] m;
         logic [3:0] eoh;
         cur = 3; val = 1'b1;
         for (int k = 0; k < 1000; k++) begin
            r   = ($urandom_range(0, 49) == 0);
            ld  = ($urandom_range(0, 3) == 0);
            li  = 2'($urandom_range(0, 3));
            adv = 1'($urandom_range(0, 1));
            m   = 4'($urandom_range(0, 15));
            w   = 1'b0;
            if (r) begin
               cur = 2; val = 1'b1;
            end else if (ld) begin
               cur = int'(li); val = 1'b1;
            end else if (adv && m != 4'b0000) begin
               if (val) begin
                  for (int d = 1; d <= 4; d++) begin
                     if (m[(cur + d) % 4]) begin
                        w   = (((cur + d) % 4) <= cur);
                        cur = (cur + d) % 4;
                        break;
                     end
                  end
               end else begin
                  for (int i = 3; i >= 0; i--) begin
                     if (m[i]) cur = i;
                  end
                  val = 1'b1;
               end
            end
            eoh = val ? (4'b0001 << cur) : 4'b0000;
            step4(r, ld, li, adv, m, eoh, val, w);
         end
      end
`endif

      for (int k = 0; k < 10 && (out_q.size() != 0 || ne_q.size() != 0); k++) begin
         @(negedge clk);
      end
      #1;
      checks++;
      if (out_q.size() != 0 || ne_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", out_q.size() + ne_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
